// File: rtl/veh_traff_light_ctrl_pkg.sv
// Shared definitions for the vehicle-side crossing controller.
// Holds the controller state enum and the default timing constants.
// Also imported by the pedestrian controller's bench model.
package veh_traff_light_ctrl_pkg;

    typedef enum logic [2:0] {
        RED_INIT   = 3'd0,
        VEH_GREEN  = 3'd1,
        VEH_YELLOW = 3'd2,
        RED_PRE    = 3'd3,
        PED_GRANT  = 3'd4,
        PED_WAIT   = 3'd5,
        RED_POST   = 3'd6,
        FAULT      = 3'd7
    } veh_state_e;

    localparam int GREEN_MIN_DEF     = 8;
    localparam int YELLOW_CYCLES_DEF = 3;
    localparam int ALLRED_CYCLES_DEF = 2;
    localparam int PED_TIMEOUT_DEF   = 16;
    localparam int CNT_W_DEF         = 5;

endpackage

// File: rtl/veh_traff_light_ctrl_phase_timer.sv
// Phase timer: counts cycles spent in the current controller state.
// Ports: clk/reset, clr_i (state entry), sat_en_i (hold at terminal count),
//        tc_val_i (terminal value to compare), tc_o (count == terminal value).
module veh_traff_light_ctrl_phase_timer
    import veh_traff_light_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             sat_en_i,
    input  logic [CNT_W-1:0] tc_val_i,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == tc_val_i);

    // States without a terminal count (PED_WAIT, FAULT) can last arbitrarily
    // long; sticking at all-ones keeps the counter from wrapping back into a
    // value that could look like a terminal count later.
    always_comb begin
        cnt_d = cnt_q + CNT_ONE;
        if (clr_i) begin
            cnt_d = '0;
        end else if ((sat_en_i && tc_o) || (cnt_q == CNT_MAX)) begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/veh_traff_light_ctrl.sv
// Vehicle-side signal controller for a pedestrian crossing: latches button
// requests, sequences green/yellow/all-red, grants the crossing to the
// pedestrian controller and latches a sticky all-red fault on protocol errors.
// Ports: clk, reset (async, active-high); ped_request_i; ped_green_i, ped_red_i,
//        ped_countdown_i (pedestrian status); veh_green_o/veh_yellow_o/veh_red_o
//        lamps; ped_grant_o; req_pending_o; fault_o. All outputs are registered.
module veh_traff_light_ctrl
    import veh_traff_light_ctrl_pkg::*;
#(
    parameter int GREEN_MIN     = GREEN_MIN_DEF,
    parameter int YELLOW_CYCLES = YELLOW_CYCLES_DEF,
    parameter int ALLRED_CYCLES = ALLRED_CYCLES_DEF,
    parameter int PED_TIMEOUT   = PED_TIMEOUT_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_request_i,
    input  logic       ped_green_i,
    input  logic       ped_red_i,
    input  logic [1:0] ped_countdown_i,
    output logic       veh_green_o,
    output logic       veh_yellow_o,
    output logic       veh_red_o,
    output logic       ped_grant_o,
    output logic       req_pending_o,
    output logic       fault_o
);

    // A state lasting N cycles leaves when the timer reads N-1.
    localparam logic [CNT_W-1:0] GREEN_TC  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] YELLOW_TC = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALLRED_TC = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [CNT_W-1:0] PED_TO_TC = CNT_W'(PED_TIMEOUT - 1);

    veh_state_e       state_q;
    veh_state_e       state_d;
    logic             req_pending_q;
    logic             req_pending_d;

    logic             veh_green_q;
    logic             veh_yellow_q;
    logic             veh_red_q;
    logic             ped_grant_q;
    logic             fault_q;

    logic             timer_clr;
    logic             timer_sat;
    logic             timer_tc;
    logic [CNT_W-1:0] timer_tc_val;

    // Terminal value and saturation depend only on the current state; kept
    // apart from the next-state logic so no combinational path loops through
    // the timer's compare.
    always_comb begin
        timer_tc_val = '0;
        timer_sat    = 1'b0;
        case (state_q)
            RED_INIT, RED_PRE, RED_POST: timer_tc_val = ALLRED_TC;
            VEH_GREEN: begin
                timer_tc_val = GREEN_TC;
                timer_sat    = 1'b1;
            end
            VEH_YELLOW: timer_tc_val = YELLOW_TC;
            PED_GRANT:  timer_tc_val = PED_TO_TC;
            default:    timer_tc_val = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        req_pending_d = req_pending_q | ped_request_i;
        case (state_q)
            RED_INIT: begin
                if (timer_tc) state_d = VEH_GREEN;
            end
            VEH_GREEN: begin
                // A pedestrian green while vehicles may move is a conflict.
                if (ped_green_i) begin
                    state_d = FAULT;
                end else if (req_pending_q && timer_tc) begin
                    state_d = VEH_YELLOW;
                end
            end
            VEH_YELLOW: begin
                if (ped_green_i) begin
                    state_d = FAULT;
                end else if (timer_tc) begin
                    state_d = RED_PRE;
                end
            end
            RED_PRE: begin
                if (timer_tc) begin
                    state_d       = PED_GRANT;
                    // The request is now being served; clearing beats a
                    // simultaneous new press.
                    req_pending_d = 1'b0;
                end
            end
            PED_GRANT: begin
                if (ped_green_i) begin
                    state_d = PED_WAIT;
                end else if (timer_tc) begin
                    state_d = FAULT;
                end
            end
            PED_WAIT: begin
                if (ped_red_i && !ped_green_i && (ped_countdown_i == 2'd0)) begin
                    state_d = RED_POST;
                end
            end
            RED_POST: begin
                if (timer_tc) state_d = VEH_GREEN;
            end
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    assign timer_clr = (state_d != state_q);

    veh_traff_light_ctrl_phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (timer_clr),
        .sat_en_i (timer_sat),
        .tc_val_i (timer_tc_val),
        .tc_o     (timer_tc)
    );

    // Outputs are flopped from the next-state decode so they line up with
    // the state register and carry no input-to-output combinational path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RED_INIT;
            req_pending_q <= 1'b0;
            veh_green_q   <= 1'b0;
            veh_yellow_q  <= 1'b0;
            veh_red_q     <= 1'b1;
            ped_grant_q   <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_pending_q <= req_pending_d;
            veh_green_q   <= (state_d == VEH_GREEN);
            veh_yellow_q  <= (state_d == VEH_YELLOW);
            veh_red_q     <= (state_d != VEH_GREEN) && (state_d != VEH_YELLOW);
            ped_grant_q   <= (state_d == PED_GRANT);
            fault_q       <= (state_d == FAULT);
        end
    end

    assign veh_green_o   = veh_green_q;
    assign veh_yellow_o  = veh_yellow_q;
    assign veh_red_o     = veh_red_q;
    assign ped_grant_o   = ped_grant_q;
    assign req_pending_o = req_pending_q;
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_veh_traff_light_ctrl.sv
module tb_veh_traff_light_ctrl;
    import veh_traff_light_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       ped_request;
    logic       ped_green;
    logic       ped_red;
    logic [1:0] ped_countdown;
    logic       veh_green, veh_yellow, veh_red, ped_grant, req_pending, fault;

    int checks = 0;
    int errors = 0;

    // {green, yellow, red, grant, req_pending, fault}
    localparam logic [5:0] RST_VEC   = 6'b001000;
    localparam logic [5:0] GREEN_VEC = 6'b100000;
    localparam logic [5:0] FAULT_VEC = 6'b001001;

    logic [5:0] obs;
    assign obs = {veh_green, veh_yellow, veh_red, ped_grant, req_pending, fault};

    veh_traff_light_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .ped_request_i   (ped_request),
        .ped_green_i     (ped_green),
        .ped_red_i       (ped_red),
        .ped_countdown_i (ped_countdown),
        .veh_green_o     (veh_green),
        .veh_yellow_o    (veh_yellow),
        .veh_red_o       (veh_red),
        .ped_grant_o     (ped_grant),
        .req_pending_o   (req_pending),
        .fault_o         (fault)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus elapsed cycles in that phase, with
    // durations taken straight from the timing rules.
    localparam int P_INIT = 0, P_GREEN = 1, P_YELLOW = 2, P_PRE = 3,
                   P_GRANT = 4, P_WAIT = 5, P_POST = 6, P_FAULT = 7;
    int m_ph, m_age, m_nxt;
    bit m_req, m_nreq;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph = P_INIT; m_age = 0; m_req = 1'b0;
        end else begin
            m_nxt  = m_ph;
            m_nreq = m_req | ped_request;
            case (m_ph)
                P_INIT:   if (m_age + 1 >= ALLRED_CYCLES_DEF) m_nxt = P_GREEN;
                P_GREEN:  if (ped_green) m_nxt = P_FAULT;
                          else if (m_req && m_age + 1 >= GREEN_MIN_DEF) m_nxt = P_YELLOW;
                P_YELLOW: if (ped_green) m_nxt = P_FAULT;
                          else if (m_age + 1 >= YELLOW_CYCLES_DEF) m_nxt = P_PRE;
                P_PRE:    if (m_age + 1 >= ALLRED_CYCLES_DEF) begin
                              m_nxt = P_GRANT; m_nreq = 1'b0;
                          end
                P_GRANT:  if (ped_green) m_nxt = P_WAIT;
                          else if (m_age + 1 >= PED_TIMEOUT_DEF) m_nxt = P_FAULT;
                P_WAIT:   if (ped_red && !ped_green && ped_countdown == 2'd0) m_nxt = P_POST;
                P_POST:   if (m_age + 1 >= ALLRED_CYCLES_DEF) m_nxt = P_GREEN;
                default:  m_nxt = m_ph;
            endcase
            m_age = (m_nxt == m_ph) ? m_age + 1 : 0;
            m_ph  = m_nxt;
            m_req = m_nreq;
        end
    end

    function automatic logic [5:0] m_exp();
        logic g, y;
        g = (m_ph == P_GREEN);
        y = (m_ph == P_YELLOW);
        return {g, y, !(g || y), m_ph == P_GRANT, m_req, m_ph == P_FAULT};
    endfunction

    task automatic check(input string tag, input logic [5:0] o, input logic [5:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic checki(input string tag, input int o, input int e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check("model", obs, m_exp());
    endtask

    // Called at a falling edge: asserts reset mid-cycle, checks that outputs
    // dropped to reset values with no clock edge, releases before the next edge.
    task automatic do_reset();
        #1 reset = 1'b1;
        #1 check("async_rst", obs, RST_VEC);
        check("async_rst_model", obs, m_exp());
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst", obs, m_exp());
    endtask

    task automatic ped_idle();
        ped_green = 1'b0; ped_red = 1'b1; ped_countdown = 2'd0;
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (!ped_grant && n < 60) begin tick(); n++; end
        checki(tag, int'(ped_grant), 1);
    endtask

    initial begin
        int gc, yc, rc, g, ps, dly, gl;
        reset = 1'b0; ped_request = 1'b0; ped_idle();
        #1 reset = 1'b1;

        // 1: reset and release
        @(negedge clk);
        check("reset_held", obs, RST_VEC);
        reset = 1'b0;
        check("rel_cycle0", obs, RST_VEC);
        tick(); check("rel_cycle1", obs, RST_VEC);
        tick(); check("rel_cycle2_green", obs, GREEN_VEC);

        // 2: no request keeps green
        repeat (60) tick();
        check("idle_green", obs, GREEN_VEC);

        // 3: full crossing
        do_reset();
        tick();                       // green cycle 0
        repeat (3) tick();            // green cycle 3
        ped_request = 1'b1; tick(); ped_request = 1'b0;
        checki("req_latched", int'(req_pending), 1);
        gc = 4;
        while (!veh_yellow && gc < 40) begin tick(); gc++; end
        checki("yellow_start_cycle", gc, 8);
        yc = 0;
        while (veh_yellow && yc < 20) begin yc++; tick(); end
        checki("yellow_len", yc, 3);
        rc = 0;
        while (veh_red && !ped_grant && rc < 20) begin rc++; tick(); end
        checki("red_pre_len", rc, 2);
        checki("grant_up", int'(ped_grant), 1);
        tick(); tick();
        checki("grant_held", int'(ped_grant), 1);
        ped_green = 1'b1; ped_red = 1'b0; ped_countdown = 2'd3;
        tick();
        checki("grant_drop", int'(ped_grant), 0);
        repeat (3) begin ped_countdown = ped_countdown - 2'd1; tick(); end
        ped_idle();
        rc = 0;
        while (!veh_green && rc < 20) begin tick(); if (!veh_green) rc++; end
        checki("red_post_len", rc, 2);
        check("back_green", obs, GREEN_VEC);

        // 4: grant timeout
        ped_request = 1'b1; tick(); ped_request = 1'b0;
        wait_grant("t4_grant");
        g = 0;
        while (ped_grant && g < 40) begin g++; tick(); end
        checki("grant_timeout_len", g, 16);
        check("timeout_fault", obs, FAULT_VEC);
        repeat (40) tick();
        check("fault_sticky", obs, FAULT_VEC);

        // 6a: reset out of FAULT
        do_reset();
        tick(); check("fault_rst_green", obs, GREEN_VEC);

        // 5: conflicting pedestrian green
        repeat (3) tick();
        ped_green = 1'b1; ped_red = 1'b0;
        tick(); check("conflict_fault", obs, FAULT_VEC);
        ped_idle();
        tick(); check("conflict_sticky", obs, FAULT_VEC);
        do_reset();
        tick();

        // 6b: reset during PED_WAIT
        ped_request = 1'b1; tick(); ped_request = 1'b0;
        wait_grant("t6_grant");
        ped_green = 1'b1; ped_red = 1'b0; ped_countdown = 2'd2;
        tick(); tick();
        check("in_ped_wait", obs, RST_VEC);
        ped_idle();
        do_reset();
        tick(); check("wait_rst_green", obs, GREEN_VEC);

        // Randomized run with a well-behaved pedestrian side that sometimes
        // answers late or glitches its green.
        ps = 0; dly = 0; gl = 0;
        for (int i = 0; i < 1500; i++) begin
            ped_request = ($urandom_range(0, 7) == 0);
            case (ps)
                0: begin
                    ped_idle();
                    if (ped_grant) begin
                        dly = ($urandom_range(0, 9) == 0) ? 18 : int'($urandom_range(0, 5));
                        ps = 1;
                    end
                end
                1: begin
                    if (dly == 0) begin
                        ped_green = 1'b1; ped_red = 1'b0;
                        ped_countdown = 2'($urandom_range(1, 3));
                        gl = $urandom_range(1, 6);
                        ps = 2;
                    end else begin
                        dly--;
                    end
                end
                2: begin
                    if (gl == 0) begin
                        ped_green = 1'b0; ped_red = 1'b1; ped_countdown = 2'd1;
                        ps = 3;
                    end else begin
                        gl--;
                        ped_countdown = 2'($urandom_range(0, 3));
                    end
                end
                default: begin
                    ped_countdown = 2'd0;
                    ps = 0;
                end
            endcase
            if ($urandom_range(0, 299) == 0) begin
                ped_green = 1'b1; ped_red = 1'b0;
            end
            tick();
            if (fault) begin
                ped_request = 1'b0; ped_idle(); ps = 0;
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
